// File: rtl/wiscsp_pkg.sv
// Shared types and defaults for the WiscSP13 pipeline registers.
// Holds the MEM-stage control bundle and the datapath/specifier width defaults.
package wiscsp_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_REG_ID_W = 3;

  typedef struct packed {
    logic reg_write;
    logic branch;
    logic mem_write;
    logic mem_read;
    logic halt;
  } mem_ctrl_t;

  localparam mem_ctrl_t MEM_CTRL_NOP = '0;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ex_mem_fwd_cmp.sv
// Store-data forwarding comparator: does the WB write target the rs2 of a valid store?
// Pure combinational; used for both the EX capture path and the MEM hold path.
module ex_mem_fwd_cmp #(
  parameter int REG_ID_W = 3
) (
  input  logic                wb_reg_write,
  input  logic [REG_ID_W-1:0] wb_rd_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  input  logic                mem_write,
  input  logic                valid,
  output logic                fwd_hit
);

  // r0 is an ordinary register here, so the match is plain full-width equality.
  assign fwd_hit = wb_reg_write & (wb_rd_id == rs2_id) & mem_write & valid;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register for WiscSP13: stall-hold, deferred flush, WB->MEM store forwarding, halt.
// Optional macro EX_MEM_STATS_EN adds saturating load/store/bubble counters.
module ex_mem_pipe
  import wiscsp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_ID_W = DEF_REG_ID_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   ex_PC2,
  input  logic [DATA_W-1:0]   ex_imm,
  input  logic                ex_branch_sel,
  input  logic [DATA_W-1:0]   ex_out,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic [REG_ID_W-1:0] ex_rs2_id,
  input  logic [REG_ID_W-1:0] ex_rd_id,
  input  logic                ex_reg_write,
  input  logic                ex_branch,
  input  logic                ex_mem_write,
  input  logic                ex_mem_read,
  input  logic                ex_halt,
  input  logic                wb_reg_write,
  input  logic [REG_ID_W-1:0] wb_rd_id,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_PC2,
  output logic [DATA_W-1:0]   mem_imm,
  output logic [DATA_W-1:0]   mem_EX_out,
  output logic [DATA_W-1:0]   mem_store_data,
  output logic                mem_branch_sel,
  output logic                mem_branch,
  output logic                mem_mem_write,
  output logic                mem_mem_read,
  output logic                mem_reg_write,
  output logic                mem_halt,
  output logic [REG_ID_W-1:0] mem_rs2_id,
  output logic [REG_ID_W-1:0] mem_rd_id,
`ifdef EX_MEM_STATS_EN
  output logic [15:0]         stat_loads,
  output logic [15:0]         stat_stores,
  output logic [15:0]         stat_bubbles,
`endif
  output logic                halted
);

  logic                valid_reg;
  logic [DATA_W-1:0]   pc2_reg;
  logic [DATA_W-1:0]   imm_reg;
  logic [DATA_W-1:0]   ex_out_reg;
  logic [DATA_W-1:0]   store_data_reg;
  logic                branch_sel_reg;
  logic [REG_ID_W-1:0] rs2_id_reg;
  logic [REG_ID_W-1:0] rd_id_reg;
  mem_ctrl_t           ctrl_reg;
  logic                flush_pend_reg;
  logic                halted_reg;

  mem_ctrl_t           ex_ctrl;
  logic [DATA_W-1:0]   store_data_next;
  logic                cap_fwd_hit;
  logic                hold_fwd_hit;

  logic                do_hold;
  logic                do_halt;
  logic                do_bubble;
  logic                do_load;

  ex_mem_fwd_cmp #(.REG_ID_W(REG_ID_W)) u_cap_cmp (
    .wb_reg_write (wb_reg_write),
    .wb_rd_id     (wb_rd_id),
    .rs2_id       (ex_rs2_id),
    .mem_write    (ex_mem_write),
    .valid        (ex_valid),
    .fwd_hit      (cap_fwd_hit)
  );

  ex_mem_fwd_cmp #(.REG_ID_W(REG_ID_W)) u_hold_cmp (
    .wb_reg_write (wb_reg_write),
    .wb_rd_id     (wb_rd_id),
    .rs2_id       (rs2_id_reg),
    .mem_write    (ctrl_reg.mem_write),
    .valid        (valid_reg),
    .fwd_hit      (hold_fwd_hit)
  );

  always_comb begin
    ex_ctrl = MEM_CTRL_NOP;
    if (ex_valid) begin
      ex_ctrl = '{reg_write: ex_reg_write, branch: ex_branch, mem_write: ex_mem_write,
                  mem_read: ex_mem_read, halt: ex_halt};
    end
  end

  assign store_data_next = cap_fwd_hit ? wb_data : ex_store_data;

  // Exactly one edge action is chosen; a halted core takes none of them.
  always_comb begin
    do_hold   = 1'b0;
    do_halt   = 1'b0;
    do_bubble = 1'b0;
    do_load   = 1'b0;
    if (!halted_reg) begin
      if (stall) begin
        do_hold = 1'b1;
      end else if (valid_reg && ctrl_reg.halt) begin
        do_halt = 1'b1;
      end else if (flush || flush_pend_reg) begin
        do_bubble = 1'b1;
      end else begin
        do_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg      <= 1'b0;
      pc2_reg        <= '0;
      imm_reg        <= '0;
      ex_out_reg     <= '0;
      store_data_reg <= '0;
      branch_sel_reg <= 1'b0;
      rs2_id_reg     <= '0;
      rd_id_reg      <= '0;
      ctrl_reg       <= MEM_CTRL_NOP;
      flush_pend_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      if (do_hold) begin
        // A flush seen while stalled is remembered and applied once the stall lifts.
        if (flush) begin
          flush_pend_reg <= 1'b1;
        end
        if (hold_fwd_hit) begin
          store_data_reg <= wb_data;
        end
      end
      if (do_halt) begin
        halted_reg     <= 1'b1;
        valid_reg      <= 1'b0;
        ctrl_reg       <= MEM_CTRL_NOP;
        flush_pend_reg <= 1'b0;
      end
      if (do_bubble) begin
        valid_reg      <= 1'b0;
        pc2_reg        <= '0;
        imm_reg        <= '0;
        ex_out_reg     <= '0;
        store_data_reg <= '0;
        branch_sel_reg <= 1'b0;
        rs2_id_reg     <= '0;
        rd_id_reg      <= '0;
        ctrl_reg       <= MEM_CTRL_NOP;
        flush_pend_reg <= 1'b0;
      end
      if (do_load) begin
        valid_reg      <= ex_valid;
        pc2_reg        <= ex_PC2;
        imm_reg        <= ex_imm;
        ex_out_reg     <= ex_out;
        store_data_reg <= store_data_next;
        branch_sel_reg <= ex_branch_sel;
        rs2_id_reg     <= ex_rs2_id;
        rd_id_reg      <= ex_rd_id;
        ctrl_reg       <= ex_ctrl;
      end
    end
  end

  assign mem_valid      = valid_reg;
  assign mem_PC2        = pc2_reg;
  assign mem_imm        = imm_reg;
  assign mem_EX_out     = ex_out_reg;
  assign mem_store_data = store_data_reg;
  assign mem_branch_sel = branch_sel_reg;
  assign mem_rs2_id     = rs2_id_reg;
  assign mem_rd_id      = rd_id_reg;
  assign mem_reg_write  = ctrl_reg.reg_write;
  assign mem_branch     = ctrl_reg.branch;
  assign mem_mem_write  = ctrl_reg.mem_write;
  assign mem_mem_read   = ctrl_reg.mem_read;
  assign mem_halt       = ctrl_reg.halt;
  assign halted         = halted_reg;

`ifdef EX_MEM_STATS_EN
  logic [2:0] stat_evt;

  // Index 0: loads, 1: stores, 2: bubbles. do_* are already quiet while halted.
  assign stat_evt = {do_bubble, do_load & ex_ctrl.mem_write, do_load & ex_ctrl.mem_read};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (stat_evt[gi]) begin
        cnt_reg <= sat_inc16(cnt_reg);
      end
    end
  end

  assign stat_loads   = g_stat[0].cnt_reg;
  assign stat_stores  = g_stat[1].cnt_reg;
  assign stat_bubbles = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios plus randomized traffic vs. a behavioural model.
// Stats checks are compiled in when EX_MEM_STATS_EN is defined.
module tb_ex_mem_pipe;

  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst, stall, flush, ex_valid;
  logic [DW-1:0] ex_PC2, ex_imm, ex_out, ex_store_data, wb_data;
  logic          ex_branch_sel, ex_reg_write, ex_branch, ex_mem_write, ex_mem_read, ex_halt;
  logic [RW-1:0] ex_rs2_id, ex_rd_id, wb_rd_id;
  logic          wb_reg_write;

  logic          mem_valid, mem_branch_sel, mem_branch, mem_mem_write, mem_mem_read;
  logic          mem_reg_write, mem_halt, halted;
  logic [DW-1:0] mem_PC2, mem_imm, mem_EX_out, mem_store_data;
  logic [RW-1:0] mem_rs2_id, mem_rd_id;
`ifdef EX_MEM_STATS_EN
  logic [15:0]   stat_loads, stat_stores, stat_bubbles;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe #(.DATA_W(DW), .REG_ID_W(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_PC2(ex_PC2), .ex_imm(ex_imm), .ex_branch_sel(ex_branch_sel), .ex_out(ex_out),
    .ex_store_data(ex_store_data), .ex_rs2_id(ex_rs2_id), .ex_rd_id(ex_rd_id),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_halt(ex_halt),
    .wb_reg_write(wb_reg_write), .wb_rd_id(wb_rd_id), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_PC2(mem_PC2), .mem_imm(mem_imm), .mem_EX_out(mem_EX_out),
    .mem_store_data(mem_store_data), .mem_branch_sel(mem_branch_sel), .mem_branch(mem_branch),
    .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write),
    .mem_halt(mem_halt), .mem_rs2_id(mem_rs2_id), .mem_rd_id(mem_rd_id),
`ifdef EX_MEM_STATS_EN
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_bubbles(stat_bubbles),
`endif
    .halted(halted)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: what MEM holds after each edge ----------------
  logic          m_valid = 0, m_bsel = 0, m_rw = 0, m_br = 0, m_mw = 0, m_mr = 0, m_halt = 0;
  logic [DW-1:0] m_pc2 = 0, m_imm = 0, m_out = 0, m_sd = 0;
  logic [RW-1:0] m_rs2 = 0, m_rd = 0;
  bit            m_pend = 0, m_halted = 0;
  int            m_loads = 0, m_stores = 0, m_bubbles = 0;

  task automatic m_clear();
    {m_valid, m_bsel, m_rw, m_br, m_mw, m_mr, m_halt} = '0;
    m_pc2 = 0; m_imm = 0; m_out = 0; m_sd = 0; m_rs2 = 0; m_rd = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_clear(); m_pend = 0; m_halted = 0;
      m_loads = 0; m_stores = 0; m_bubbles = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (stall) begin
      if (flush) m_pend = 1;
      if (m_valid && m_mw && wb_reg_write && wb_rd_id == m_rs2) m_sd = wb_data;
    end else if (m_valid && m_halt) begin
      m_halted = 1; m_pend = 0;
      {m_valid, m_rw, m_br, m_mw, m_mr, m_halt} = '0;
    end else if (flush || m_pend) begin
      m_clear(); m_pend = 0;
      if (m_bubbles < 65535) m_bubbles++;
    end else begin
      m_valid = ex_valid;
      m_pc2 = ex_PC2; m_imm = ex_imm; m_out = ex_out; m_bsel = ex_branch_sel;
      m_rs2 = ex_rs2_id; m_rd = ex_rd_id;
      m_rw = ex_valid & ex_reg_write; m_br = ex_valid & ex_branch;
      m_mw = ex_valid & ex_mem_write; m_mr = ex_valid & ex_mem_read; m_halt = ex_valid & ex_halt;
      m_sd = (ex_valid && ex_mem_write && wb_reg_write && wb_rd_id == ex_rs2_id) ? wb_data : ex_store_data;
      if (m_mr && m_loads < 65535) m_loads++;
      if (m_mw && m_stores < 65535) m_stores++;
    end
  end

  // ---------------- compare process: every cycle, away from the active edge ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ctrl", 64'({mem_valid, mem_reg_write, mem_branch, mem_mem_write, mem_mem_read, mem_halt, mem_branch_sel}),
                    64'({m_valid, m_rw, m_br, m_mw, m_mr, m_halt, m_bsel}));
      check("data", {mem_PC2, mem_imm, mem_EX_out, mem_store_data}, {m_pc2, m_imm, m_out, m_sd});
      check("ids", 64'({mem_rs2_id, mem_rd_id}), 64'({m_rs2, m_rd}));
      check("halted", 64'(halted), 64'(m_halted));
`ifdef EX_MEM_STATS_EN
      check("stats", 64'({stat_loads, stat_stores, stat_bubbles}),
                     64'({m_loads[15:0], m_stores[15:0], m_bubbles[15:0]}));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    rst = 0; stall = 0; flush = 0; ex_valid = 0;
    ex_PC2 = 0; ex_imm = 0; ex_out = 0; ex_store_data = 0; ex_branch_sel = 0;
    ex_rs2_id = 0; ex_rd_id = 0;
    {ex_reg_write, ex_branch, ex_mem_write, ex_mem_read, ex_halt} = '0;
    wb_reg_write = 0; wb_rd_id = 0; wb_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_ex();
    ex_PC2 = DW'($urandom); ex_imm = DW'($urandom); ex_out = DW'($urandom);
    ex_store_data = DW'($urandom); ex_branch_sel = 1'($urandom);
    ex_rs2_id = RW'($urandom); ex_rd_id = RW'($urandom);
    {ex_reg_write, ex_branch, ex_mem_write, ex_mem_read} = 4'($urandom);
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1; step(); step();
    chk_en = 1;
    rst = 0;
    check("rst_valid", 64'(mem_valid), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_data", {mem_PC2, mem_imm, mem_EX_out, mem_store_data}, 64'h0);
    $display("txn reset");

    // Store captured with same-cycle WB forwarding
    idle(); ex_valid = 1; ex_mem_write = 1; ex_out = 16'h0040; ex_store_data = 16'h1234; ex_rs2_id = 3;
    wb_reg_write = 1; wb_rd_id = 3; wb_data = 16'hBEEF;
    step();
    check("cap_fwd_sd", 64'(mem_store_data), 64'hBEEF);
    check("cap_fwd_mw", 64'(mem_mem_write), 64'h1);
    check("cap_fwd_addr", 64'(mem_EX_out), 64'h0040);
    $display("txn store addr=0040 fwd r3=BEEF -> sd=%h", mem_store_data);

    // Held store picks up a WB write in the middle of a 3-cycle stall
    idle(); ex_valid = 1; ex_mem_write = 1; ex_out = 16'h0200; ex_store_data = 16'h1111; ex_rs2_id = 5;
    step();
    idle(); stall = 1; randomize_ex(); ex_valid = 1;
    step();
    check("hold_c1_sd", 64'(mem_store_data), 64'h1111);
    wb_reg_write = 1; wb_rd_id = 5; wb_data = 16'h00AA;
    step();
    check("hold_c2_sd", 64'(mem_store_data), 64'h00AA);
    wb_reg_write = 0;
    step();
    check("hold_c3_sd", 64'(mem_store_data), 64'h00AA);
    check("hold_c3_addr", 64'(mem_EX_out), 64'h0200);
    $display("txn stalled store rs2=5 fwd 00AA -> sd=%h", mem_store_data);

    // Flush while stalled defers to exactly one bubble
    idle(); ex_valid = 1; ex_mem_read = 1; ex_out = 16'h0100;
    step();
    idle(); stall = 1; flush = 1; ex_valid = 1; ex_mem_read = 1; ex_out = 16'h0155;
    step();
    check("defer_keep_mr", 64'(mem_mem_read), 64'h1);
    flush = 0;
    step();
    check("defer_keep_addr", 64'(mem_EX_out), 64'h0100);
    stall = 0;
    step();
    check("bubble_valid", 64'(mem_valid), 64'h0);
    check("bubble_mr", 64'(mem_mem_read), 64'h0);
    idle(); ex_valid = 1; ex_mem_read = 1; ex_out = 16'h0300;
    step();
    check("post_bubble_valid", 64'(mem_valid), 64'h1);
    check("post_bubble_addr", 64'(mem_EX_out), 64'h0300);
    $display("txn deferred flush -> one bubble then load 0300");

    // Halt
    idle(); ex_valid = 1; ex_halt = 1;
    step();
    check("halt_pre", 64'(halted), 64'h0);
    idle(); ex_valid = 1; ex_mem_write = 1; ex_out = 16'h0400;
    step();
    check("halt_set", 64'(halted), 64'h1);
    stall = 1; flush = 1;
    step();
    stall = 0; flush = 0;
    step();
    check("halt_no_mw", 64'(mem_mem_write), 64'h0);
    check("halt_no_valid", 64'(mem_valid), 64'h0);
    $display("txn halt -> halted=%0d", halted);

    // Reset mid-stream clears a pending flush
    do_reset();
    idle(); ex_valid = 1; ex_mem_write = 1; ex_out = 16'h0500;
    step();
    stall = 1; flush = 1;
    step();
    idle(); rst = 1;
    step();
    check("rst2_valid", 64'(mem_valid), 64'h0);
    check("rst2_halted", 64'(halted), 64'h0);
    idle(); ex_valid = 1; ex_mem_read = 1; ex_out = 16'h0600;
    step();
    check("rst2_no_bubble", 64'(mem_valid), 64'h1);
    check("rst2_addr", 64'(mem_EX_out), 64'h0600);
    $display("txn reset with pending flush -> first load 0600 no bubble");

`ifdef EX_MEM_STATS_EN
    do_reset();
    idle(); ex_valid = 1; ex_mem_read = 1; step(); step();
    idle(); ex_valid = 1; ex_mem_write = 1; step();
    idle(); ex_valid = 1; flush = 1; step();
    idle();
    check("stat_loads", 64'(stat_loads), 64'd2);
    check("stat_stores", 64'(stat_stores), 64'd1);
    check("stat_bubbles", 64'(stat_bubbles), 64'd1);
    $display("txn stats loads=%0d stores=%0d bubbles=%0d", stat_loads, stat_stores, stat_bubbles);
`endif

    // Randomized traffic, checked each cycle by the compare process
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 6) == 0);
      ex_valid = ($urandom_range(0, 4) != 0);
      randomize_ex();
      ex_halt = ($urandom_range(0, 59) == 0);
      wb_reg_write = 1'($urandom);
      wb_rd_id = RW'($urandom);
      wb_data = DW'($urandom);
      step();
    end
    $display("txn random traffic 3000 cycles");

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
